// File: rtl/mod_down_counter.sv
// Modulo-N synchronous down counter with borrow, parallel load and sticky done.
// Define CNT_WRAP_EN for free-running wrap; default build is one-shot.
module mod_down_counter #(
  parameter int MODULUS = 9,
  parameter int WIDTH   = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             preset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             in,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             borrow,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  typedef enum logic [1:0] {
    COUNTING,
    TERMINAL,
    EXPIRED
  } state_e;

  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] load_sat;
  state_e           state;

  assign load_sat = (load_value > MAX) ? MAX : load_value;

  always_comb begin
    state = COUNTING;
    if (count_q == '0) begin
      state = done_q ? EXPIRED : TERMINAL;
    end
  end

  always_ff @(posedge clock) begin
    count_q <= count_d;
    done_q  <= done_q == done_d ? done_q : done_d;
  end

  always_comb begin
    count_d = count_q;
    done_d  = done_q;
`ifdef CNT_WRAP_EN
    // done is a one-cycle pulse marking the wrap edge
    done_d  = 1'b0;
`endif
    if (clear) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (preset) begin
      count_d = MAX;
      done_d  = 1'b0;
    end else if (load) begin
      count_d = load_sat;
      done_d  = 1'b0;
    end else if (in) begin
      unique case (state)
        COUNTING: begin
          count_d = count_q - 1'b1;
        end
        TERMINAL: begin
`ifdef CNT_WRAP_EN
          count_d = MAX;
`endif
          done_d  = 1'b1;
        end
        EXPIRED: begin
          done_d  = 1'b1;
        end
        default: begin
          count_d = '0;
        end
      endcase
    end
  end

  assign q      = count_q;
  assign zero   = (count_q == '0);
  assign borrow = zero & in & ~clear & ~preset & ~load;
  assign done   = done_q;

endmodule

// File: tb/tb_mod_down_counter.sv
// Directed self-checking bench for mod_down_counter.
// Expectations follow CNT_WRAP_EN when it is defined for the build.
module tb_mod_down_counter;

  logic       clock;
  logic       clear, preset, load, in;
  logic [4:0] load_value;
  logic [4:0] q;
  logic       zero, borrow, done;

  logic       c2_clear, c2_preset, c2_load, c2_in;
  logic [4:0] c2_lv;
  logic [4:0] c2_q;
  logic       c2_zero, c2_borrow, c2_done;

  int checks = 0;
  int errors = 0;

  mod_down_counter #(.MODULUS(9), .WIDTH(5)) dut (
    .clock(clock), .clear(clear), .preset(preset), .load(load),
    .load_value(load_value), .in(in), .q(q), .zero(zero),
    .borrow(borrow), .done(done)
  );

  mod_down_counter #(.MODULUS(2), .WIDTH(5)) dut2 (
    .clock(clock), .clear(c2_clear), .preset(c2_preset),
    .load(c2_load), .load_value(c2_lv), .in(c2_in), .q(c2_q),
    .zero(c2_zero), .borrow(c2_borrow), .done(c2_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    clear = 0; preset = 0; load = 0; in = 0; load_value = '0;
  endtask

  task automatic test_reset();
    idle();
    clear = 1;
    #1;
    checks++;
    if (borrow !== 1'b0) begin
      errors++;
      $display("FAIL reset_borrow_pre got %b want 0", borrow);
    end
    step();
    checks++;
    if (q !== 5'd0 || zero !== 1'b1 || done !== 1'b0 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL reset got q=%0d z=%b d=%b b=%b want q=0 z=1 d=0 b=0",
               q, zero, done, borrow);
    end
    idle();
  endtask

  task automatic test_sequence();
    int eq;
    int ed;
    idle();
    preset = 1;
    step();
    checks++;
    if (q !== 5'd8 || done !== 1'b0) begin
      errors++;
      $display("FAIL seq_preset got q=%0d d=%b want q=8 d=0", q, done);
    end
    preset = 0;
    in = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (borrow !== (i == 8)) begin
        errors++;
        $display("FAIL seq_borrow i=%0d got %b want %b", i, borrow, i == 8);
      end
      step();
      eq = (i < 8) ? 7 - i : (i == 8 ? 8 : 7);
      ed = (i == 8) ? 1 : 0;
      checks++;
      if (q !== 5'(eq) || done !== 1'(ed)) begin
        errors++;
        $display("FAIL seq_step i=%0d got q=%0d d=%b want q=%0d d=%0d",
                 i, q, done, eq, ed);
      end
    end
    idle();
  endtask

  task automatic test_oneshot();
    int eq [5] = '{1, 0, 0, 0, 0};
    int ed [5] = '{0, 0, 1, 1, 1};
    idle();
    load = 1;
    load_value = 5'd2;
    step();
    checks++;
    if (q !== 5'd2 || done !== 1'b0) begin
      errors++;
      $display("FAIL os_load got q=%0d d=%b want q=2 d=0", q, done);
    end
    load = 0;
    in = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (borrow !== (i >= 2)) begin
        errors++;
        $display("FAIL os_borrow i=%0d got %b want %b", i, borrow, i >= 2);
      end
      step();
      checks++;
      if (q !== 5'(eq[i]) || done !== 1'(ed[i])) begin
        errors++;
        $display("FAIL os_step i=%0d got q=%0d d=%b want q=%0d d=%0d",
                 i, q, done, eq[i], ed[i]);
      end
    end
    in = 0;
    step();
    checks++;
    if (q !== 5'd0 || done !== 1'b1) begin
      errors++;
      $display("FAIL os_hold got q=%0d d=%b want q=0 d=1", q, done);
    end
    preset = 1;
    step();
    checks++;
    if (q !== 5'd8 || done !== 1'b0) begin
      errors++;
      $display("FAIL os_preset got q=%0d d=%b want q=8 d=0", q, done);
    end
    idle();
  endtask

  task automatic test_load_clamp();
    logic [4:0] lv [4] = '{5'd20, 5'd3, 5'd8, 5'd9};
    logic [4:0] ex [4] = '{5'd8, 5'd3, 5'd8, 5'd8};
    idle();
    load = 1;
    for (int i = 0; i < 4; i++) begin
      load_value = lv[i];
      step();
      checks++;
      if (q !== ex[i]) begin
        errors++;
        $display("FAIL load_clamp lv=%0d got q=%0d want q=%0d",
                 lv[i], q, ex[i]);
      end
    end
    idle();
  endtask

  task automatic test_priority();
    idle();
    load = 1;
    load_value = 5'd2;
    step();
    in = 1;
    load_value = 5'd5;
    step();
    checks++;
    if (q !== 5'd5) begin
      errors++;
      $display("FAIL prio_load_in got q=%0d want q=5", q);
    end
    idle();
    clear = 1;
    step();
    clear = 0;
    load = 1;
    in = 1;
    load_value = 5'd0;
    #1;
    checks++;
    if (borrow !== 1'b0) begin
      errors++;
      $display("FAIL prio_borrow_load got %b want 0", borrow);
    end
    load_value = 5'd7;
    step();
    clear = 1;
    preset = 1;
    #1;
    checks++;
    if (borrow !== 1'b0) begin
      errors++;
      $display("FAIL prio_borrow_ctl got %b want 0", borrow);
    end
    step();
    checks++;
    if (q !== 5'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL prio_clear got q=%0d d=%b want q=0 d=0", q, done);
    end
    idle();
  endtask

  task automatic test_hold();
    idle();
    load = 1;
    load_value = 5'd6;
    step();
    load = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (q !== 5'd6) begin
        errors++;
        $display("FAIL hold i=%0d got q=%0d want q=6", i, q);
      end
    end
    in = 1;
    step();
    checks++;
    if (q !== 5'd5) begin
      errors++;
      $display("FAIL hold_resume got q=%0d want q=5", q);
    end
    clear = 1;
    step();
    checks++;
    if (q !== 5'd0 || zero !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear got q=%0d z=%b d=%b want q=0 z=1 d=0",
               q, zero, done);
    end
    idle();
  endtask

  task automatic test_mod2();
    int e;
    int n;
    c2_clear = 1;
    step();
    c2_clear = 0;
    c2_preset = 1;
    step();
    c2_preset = 0;
    checks++;
    if (c2_q !== 5'd1) begin
      errors++;
      $display("FAIL m2_preset got q=%0d want q=1", c2_q);
    end
    c2_in = 1;
    e = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (c2_borrow !== (e == 0)) begin
        errors++;
        $display("FAIL m2_borrow i=%0d got %b want %b", i, c2_borrow, e == 0);
      end
`ifdef CNT_WRAP_EN
      n = (e == 0) ? 1 : 0;
`else
      n = 0;
`endif
      step();
      e = n;
      checks++;
      if (c2_q !== 5'(e)) begin
        errors++;
        $display("FAIL m2_step i=%0d got q=%0d want q=%0d", i, c2_q, e);
      end
    end
    c2_in = 0;
  endtask

  initial begin
    idle();
    c2_clear = 1; c2_preset = 0; c2_load = 0; c2_in = 0; c2_lv = '0;
    @(negedge clock);
    test_reset();
`ifdef CNT_WRAP_EN
    test_sequence();
`else
    test_oneshot();
`endif
    test_load_clamp();
    test_priority();
    test_hold();
    test_mod2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mod_down_counter.md
# mod_down_counter

5-bit synchronous modulo-N down counter, the counting-down counterpart of the team's T-flip-flop mod-N up counters. Counts from MODULUS-1 down to 0 on enabled clock edges. Provides a terminal-count borrow for cascading and a parallel load for programmable start values. All flip-flops share one clock; there are no ripple clocks or asynchronous resets.

## Interface

Parameters:
- MODULUS, 9, count length; legal range 2..32; count sequence MODULUS-1 … 0.
- WIDTH, 5, counter width; MODULUS ≤ 2^WIDTH.

Ports:
- clock  input  1  single clock, all state updates on posedge.
- clear  input  1  reset, synchronous, active-high; highest priority.
- preset  input  1  synchronous; loads MODULUS-1.
- load  input  1  synchronous parallel load of load_value.
- load_value  input  WIDTH  start value for load.
- in  input  1  count enable; count decrements only when high.
- q  output  WIDTH  registered count.
- zero  output  1  combinational, high when q == 0.
- borrow  output  1  combinational, zero & in & ~clear & ~preset & ~load; cascade enable for the next stage.
- done  output  1  registered sticky flag; see Configuration.

## Operation

- Per-edge priority: clear > preset > load > count (in) > hold.
- clear: q ← 0, done ← 0.
- preset: q ← MODULUS-1, done ← 0.
- load: q ← load_value if load_value ≤ MODULUS-1; otherwise q ← MODULUS-1 (clamp). done ← 0.
- count, with in=1 and q > 0: q ← q-1.
- count, with in=1 and q == 0: behaviour depends on CNT_WRAP_EN (see Configuration).
- in=0 with no control asserted: q and done hold.
- Arithmetic is unsigned, WIDTH bits. q never takes a value ≥ MODULUS.
- States: COUNTING (q>0), TERMINAL (q==0, done=0), and, wrap disabled only, EXPIRED (q==0, done=1).
  - COUNTING→TERMINAL on the decrement from 1.
  - TERMINAL→COUNTING on wrap.
  - TERMINAL→EXPIRED on an enabled edge when wrap is disabled.
  - Any state→COUNTING or TERMINAL on clear, preset or load, according to the value written.

## Timing

- Reset value, after one clock with clear=1: q=0, zero=1, done=0. borrow=0 while clear is high.
- Latency: control or enable sampled at edge N is visible on q after edge N. zero follows q in the same cycle.
- borrow is high for exactly one cycle per wrap when in is held high. It is asserted in the cycle before the wrap edge.
- Simultaneous load and in: load wins and no decrement occurs that cycle.
- Simultaneous clear with anything: clear wins.
- clear asserted mid-count: q=0 after that edge, regardless of in.
- MODULUS=2: the count toggles 1,0,1,0… and borrow is high every other cycle.

## Configuration

- Macro: CNT_WRAP_EN.
- Defined (free-running):
  - An enabled edge at q==0 reloads q ← MODULUS-1.
  - done pulses high for one cycle after the wrap edge.
  - borrow behaves as a periodic cascade carry.
- Undefined (one-shot):
  - An enabled edge at q==0 leaves q=0 and sets done=1.
  - done stays set until clear, preset or load.
  - borrow is still generated at q==0 & in, so a cascade sees a borrow every cycle while expired.

## Test plan

- Reset: clear=1 for 1 cycle, in=0 -> q=0, zero=1, done=0, borrow=0.
- Full sequence, MODULUS=9, wrap enabled: preset, then in=1 for 10 cycles -> q steps 8,7,…,0,8. borrow high only in the q=0 cycle. done pulses once, after the edge q: 0→8.
- Load clamp: load=1 with load_value=20, MODULUS=9 -> q=8. Load with load_value=3 -> q=3.
- Priority: load=1, load_value=5, in=1, q=2 -> q=5. Then clear=1, preset=1, load=1 -> q=0.
- Hold and mid-count reset: q=6, in=0 for 3 cycles -> q stays 6. clear pulse with in=1 -> q=0.
- One-shot build (CNT_WRAP_EN undefined): load 2, in=1 for 5 cycles -> q 1,0,0,0,0. done=1 from the third edge onward. preset -> done=0, q=8.
